// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage: reads the register file for decoded instructions, stalls RAW/WAW hazards via a busy-bit scoreboard.
// Optional writeback forwarding in FETCH is enabled by defining REGFILE_OPERAND_FETCH_BYPASS_EN.
module regfile_operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_wen,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_wen,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW-1:0]   rf_read_address_1,
    output logic [AW-1:0]   rf_read_address_2,
    input  logic [XLEN-1:0] rf_read_data_1,
    input  logic [XLEN-1:0] rf_read_data_2,
    output logic [AW-1:0]   rf_write_address,
    output logic [XLEN-1:0] rf_write_value,
    output logic            rf_write_enable
);

    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

    state_t          state_q;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic            rd_wen_q;
    logic [NREG-1:0] busy_q, busy_d;
    logic            ex_valid_q, ex_rd_wen_q;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs2_data_q;
    logic [AW-1:0]   ex_rd_q;

    logic            wb_we, id_fire, capture;
    logic            wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic            rs1_busy, rs2_busy, rd_busy;
    logic [XLEN-1:0] op1, op2;

    assign wb_we            = wb_valid && (wb_rd != '0);
    assign rf_write_address = wb_rd;
    assign rf_write_value   = wb_data;
    assign rf_write_enable  = wb_we;

    assign rf_read_address_1 = rs1_q;
    assign rf_read_address_2 = rs2_q;

    assign id_ready = (state_q == IDLE) || ((state_q == OUT) && ex_ready);
    assign id_fire  = id_valid && id_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wb_hit_rs1 = 1'b0;
        wb_hit_rs2 = 1'b0;
        wb_hit_rd  = 1'b0;
`ifdef REGFILE_OPERAND_FETCH_BYPASS_EN
        wb_hit_rs1 = wb_we && (wb_rd == rs1_q);
        wb_hit_rs2 = wb_we && (wb_rd == rs2_q);
        wb_hit_rd  = wb_we && (wb_rd == rd_q);
`endif
        rs1_busy = (rs1_q != '0) && busy_q[rs1_q] && !wb_hit_rs1;
        rs2_busy = (rs2_q != '0) && busy_q[rs2_q] && !wb_hit_rs2;
        rd_busy  = rd_wen_q && (rd_q != '0) && busy_q[rd_q] && !wb_hit_rd;
        capture  = (state_q == FETCH) && !(rs1_busy || rs2_busy || rd_busy);

        op1 = (rs1_q == '0) ? '0 : (wb_hit_rs1 ? wb_data : rf_read_data_1);
        op2 = (rs2_q == '0) ? '0 : (wb_hit_rs2 ? wb_data : rf_read_data_2);

        // Clear before set so a same-edge set of the same index wins.
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (capture && rd_wen_q && (rd_q != '0)) busy_d[rd_q] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rd_wen_q      <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rd_q       <= '0;
            ex_rd_wen_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (id_fire) begin
                rs1_q    <= id_rs1;
                rs2_q    <= id_rs2;
                rd_q     <= id_rd;
                rd_wen_q <= id_rd_wen;
            end
            case (state_q)
                IDLE: begin
                    if (id_fire) state_q <= FETCH;
                end
                FETCH: begin
                    if (capture) begin
                        ex_rs1_data_q <= op1;
                        ex_rs2_data_q <= op2;
                        ex_rd_q       <= rd_q;
                        ex_rd_wen_q   <= rd_wen_q;
                        ex_valid_q    <= 1'b1;
                        state_q       <= OUT;
                    end
                end
                OUT: begin
                    if (ex_ready) begin
                        ex_valid_q <= 1'b0;
                        state_q    <= id_fire ? FETCH : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rd_wen   = ex_rd_wen_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a negedge register file model alongside.
// Build with +define+REGFILE_OPERAND_FETCH_BYPASS_EN to exercise the forwarding variant.
module tb_regfile_operand_fetch;

    logic        clk, rst;
    logic        id_valid, id_ready, id_rd_wen;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_valid, ex_ready, ex_rd_wen;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rf_read_address_1, rf_read_address_2, rf_write_address;
    logic [31:0] rf_read_data_1, rf_read_data_2, rf_write_value;
    logic        rf_write_enable;

    int errors = 0;
    int checks = 0;

    regfile_operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .rf_write_address(rf_write_address), .rf_write_value(rf_write_value),
        .rf_write_enable(rf_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: reads and writes on the same negedge, reads see the old value, x0 protected.
    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(negedge clk) begin
        rf_read_data_1 <= mem[rf_read_address_1];
        rf_read_data_2 <= mem[rf_read_address_2];
        if (rf_write_enable && rf_write_address != 5'd0) mem[rf_write_address] <= rf_write_value;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
        id_valid  = 1'b1;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_rd_wen = wen;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_wen = 0;
        ex_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        step();
        step();
        rst = 1'b0;
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_id_ready", id_ready, 1'b1);
        check("rst_wen", rf_write_enable, 1'b0);
        check("rst_ex_rs1", ex_rs1_data, 32'h0);

        // Writeback x5, then read it with rs2=x0.
        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        #1;
        check("wb5_wen", rf_write_enable, 1'b1);
        check("wb5_addr", rf_write_address, 32'd5);
        check("wb5_val", rf_write_value, 32'h0000_1234);
        step();
        wb_valid = 0;
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        step();                                   // edge E
        id_valid = 0;
        check("fetch_addr1", rf_read_address_1, 32'd5);
        check("fetch_ex_valid", ex_valid, 1'b0);
        check("fetch_id_ready", id_ready, 1'b0);
        step();                                   // edge E+1
        check("e1_ex_valid", ex_valid, 1'b1);
        check("e1_rs1", ex_rs1_data, 32'h0000_1234);
        check("e1_rs2", ex_rs2_data, 32'h0);
        ex_ready = 1;
        step();
        ex_ready = 0;
        check("drain_ex_valid", ex_valid, 1'b0);
        check("drain_id_ready", id_ready, 1'b1);

        // Mark x6 busy, then RAW on x6 resolved by writeback.
        issue(5'd0, 5'd0, 5'd6, 1'b1);
        step();
        id_valid = 0;
        step();
        check("rd6_ex_valid", ex_valid, 1'b1);
        check("rd6_ex_rd", ex_rd, 32'd6);
        check("rd6_ex_wen", ex_rd_wen, 1'b1);
        ex_ready = 1;
        step();
        ex_ready = 0;
        issue(5'd6, 5'd0, 5'd0, 1'b0);
        step();
        id_valid = 0;
        step();
        check("raw_stall1", ex_valid, 1'b0);
        step();
        check("raw_stall2", ex_valid, 1'b0);
        wb_valid = 1; wb_rd = 5'd6; wb_data = 32'h0000_DEAD;
        step();                                   // edge W
        wb_valid = 0;
`ifdef REGFILE_OPERAND_FETCH_BYPASS_EN
        check("raw_w_ex_valid", ex_valid, 1'b1);
        check("raw_w_rs1", ex_rs1_data, 32'h0000_DEAD);
`else
        check("raw_w_ex_valid", ex_valid, 1'b0);
        step();                                   // edge W+1
        check("raw_w1_ex_valid", ex_valid, 1'b1);
        check("raw_w1_rs1", ex_rs1_data, 32'h0000_DEAD);
`endif
        ex_ready = 1;
        step();
        ex_ready = 0;

        // Writeback to x0 is suppressed; reading x0 never stalls.
        wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        check("wb0_wen", rf_write_enable, 1'b0);
        step();
        wb_valid = 0;
        issue(5'd0, 5'd0, 5'd0, 1'b0);
        step();
        id_valid = 0;
        step();
        check("x0_ex_valid", ex_valid, 1'b1);
        check("x0_rs1", ex_rs1_data, 32'h0);

        // Hold OUT for 5 cycles with distinct operands.
        ex_ready = 1;
        step();
        ex_ready = 0;
        issue(5'd5, 5'd6, 5'd0, 1'b0);
        step();
        id_valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_ex_valid", ex_valid, 1'b1);
            check("hold_id_ready", id_ready, 1'b0);
            check("hold_rs1", ex_rs1_data, 32'h0000_1234);
            check("hold_rs2", ex_rs2_data, 32'h0000_DEAD);
            step();
        end
        ex_ready = 1;
        issue(5'd6, 5'd5, 5'd0, 1'b0);
        #1;
        check("b2b_id_ready", id_ready, 1'b1);
        step();
        id_valid = 0;
        ex_ready = 0;
        check("b2b_ex_valid_drop", ex_valid, 1'b0);
        check("b2b_fetch_addr1", rf_read_address_1, 32'd6);
        step();
        check("b2b_ex_valid", ex_valid, 1'b1);
        check("b2b_rs1", ex_rs1_data, 32'h0000_DEAD);
        check("b2b_rs2", ex_rs2_data, 32'h0000_1234);
        ex_ready = 1;
        step();
        ex_ready = 0;

        // Stall on busy x7, reset mid-cycle, then x7 reads without stalling.
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        step();
        id_valid = 0;
        step();
        ex_ready = 1;
        step();
        ex_ready = 0;
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        step();
        id_valid = 0;
        step();
        check("x7_stall", ex_valid, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ex_valid", ex_valid, 1'b0);
        check("arst_id_ready", id_ready, 1'b1);
        check("arst_wen", rf_write_enable, 1'b0);
        step();
        rst = 1'b0;
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        step();
        id_valid = 0;
        check("post_rst_fetch", ex_valid, 1'b0);
        step();
        check("post_rst_ex_valid", ex_valid, 1'b1);
        check("post_rst_rs1", ex_rs1_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Initiator side of the 32x32 RISC-V register file: takes decoded instructions (rs1/rs2/rd), drives the register file read ports, captures operands and hands them to execute over a valid/ready handshake.
- Owns the register file write port for writeback and keeps a busy-bit scoreboard that stalls RAW/WAW hazards.
- Sits between decode and execute; the register file itself (negedge-latched reads/writes, x0 write-protected) is instantiated alongside.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  decoded instruction available
- id_ready  output  1  block accepts instruction
- id_rs1, id_rs2, id_rd  input  AW each  source/destination register indices
- id_rd_wen  input  1  instruction will write rd
- ex_valid  output  1  operands valid for execute
- ex_ready  input  1  execute accepts operands
- ex_rs1_data, ex_rs2_data  output  XLEN each  fetched operands
- ex_rd  output  AW  destination index passed through
- ex_rd_wen  output  1  rd write flag passed through
- wb_valid  input  1  writeback request this cycle
- wb_rd  input  AW  writeback index
- wb_data  input  XLEN  writeback value
- rf_read_address_1, rf_read_address_2  output  AW each  to register file
- rf_read_data_1, rf_read_data_2  input  XLEN each  from register file
- rf_write_address  output  AW  to register file
- rf_write_value  output  XLEN  to register file
- rf_write_enable  output  1  to register file

Behaviour:
- Reset (async, rst=1): state=IDLE, busy[] all 0, ex_valid=0, ex_* data/index regs=0, latched instruction=0. Reset mid-operation drops the in-flight instruction and clears the scoreboard.
- FSM states: IDLE, FETCH, OUT.
- id_ready = (state==IDLE) || (state==OUT && ex_ready). A handshake (id_valid && id_ready) latches rs1/rs2/rd/rd_wen and moves to FETCH.
- FETCH: rf_read_address_1/2 are driven from the latched rs1/rs2 (registered, stable all cycle); the register file reads at negedge and the data is captured at the next posedge.
- Stall in FETCH when: (rs1!=0 && busy[rs1]), or (rs2!=0 && busy[rs2]), or (rd_wen && rd!=0 && busy[rd]) (WAW).
- No stall: capture operands, set busy[rd] if rd_wen && rd!=0, go to OUT with ex_valid=1. Latency: instruction accepted at edge E, ex_valid=1 from edge E+1.
- rs==0: the corresponding operand is forced to 0 regardless of rf_read_data.
- OUT: ex_* held stable while ex_ready=0. On ex_ready: go to FETCH if a new id handshake happens in the same cycle, else to IDLE; ex_valid drops unless new operands are captured.
- Write port (combinational): rf_write_address=wb_rd, rf_write_value=wb_data, rf_write_enable=wb_valid && wb_rd!=0.
- Busy clear: busy[wb_rd] clears at the posedge ending a wb_valid cycle. If the same edge sets and clears the same index, set wins.
- wb to a non-busy register still writes; the clear is a no-op. busy[0] is never set.
- Until the clear edge, a busy source stalls. The register file writes and reads on the same negedge and returns the old value, so a same-cycle read of the written register is never trusted.

Optional Feature:
- Macro: REGFILE_OPERAND_FETCH_BYPASS_EN.
- Defined: in FETCH, if wb_valid && wb_rd!=0 && wb_rd matches rs1/rs2, that source is treated as not busy and the operand is taken from wb_data instead of rf_read_data. A matching WAW on rd is likewise treated as cleared.
- Undefined: no forwarding; the instruction waits one extra cycle for busy to clear and reads the register file.

Test Plan:
- Assert rst mid-cycle (async) -> ex_valid=0, id_ready=1, rf_write_enable=0, all busy clear immediately.
- wb x5=0x00001234; then issue rs1=5, rs2=0 at edge E -> ex_valid at E+1, ex_rs1_data=0x00001234, ex_rs2_data=0, rf_read_address_1=5 during FETCH.
- Issue rd=6 wen and consume it; then issue rs1=6 (stalls); wb x6=0x0000DEAD in the cycle ending at edge W -> without macro ex_valid from W+1, with macro from W; ex_rs1_data=0x0000DEAD in both cases.
- wb_valid with wb_rd=0, wb_data=0xFFFFFFFF -> rf_write_enable=0; a later read of rs1=0 gives 0 with no stall.
- Hold ex_ready=0 for 5 cycles in OUT -> ex_* stable, id_ready=0. Raise ex_ready with id_valid=1 -> back-to-back accept, FETCH the next cycle.
- Stall on busy x7, assert rst, then issue rs1=7 -> no stall, ex_valid one cycle after acceptance.
